dodge_engine: RTL and testbench
===============================

Name: dodge_engine

Overview:
- Parametrised game core for the falling-object dodge game on the LED matrix.
- Owns grid state, NUM_OBJ independent falling objects, LFSR column selection, player movement, collision, lives and score.
- Matrix scan, 7-seg and clock dividers stay outside. They read this block through a column read port and drive it with a one-cycle move tick.

Parameters:
- COLS, 8, grid columns (player moves across columns), 2..16
- ROWS, 8, grid rows, bit 0 = top row, 4..16
- NUM_OBJ, 3, number of falling objects, 1..8
- PLAYER_H, 2, player height in rows, occupies bottom PLAYER_H rows
- LIVES, 3, starting lives, 1..7
- SPAWN_GAP, 3, ticks between successive object activations after reset or hit
- SCORE_W, 8, score counter width
- LFSR_SEED, 16'hACE1, nonzero LFSR seed

Ports:
- CLK  in  1  system clock
- clear  in  1  synchronous active-high reset
- tick  in  1  one-CLK-cycle game step enable
- Left  in  1  move request, sampled only on tick
- Right  in  1  move request, sampled only on tick
- rd_col  in  $clog2(COLS)  column to read, combinational
- obj_row_n  out  ROWS  active-low object bits of column rd_col
- player_row_n  out  ROWS  active-low player bits of column rd_col
- player_col  out  $clog2(COLS)  current player column
- lives  out  3  remaining lives
- life_bar  out  LIVES  thermometer of lives, LSB-aligned, 1 = lit
- score  out  SCORE_W  objects dodged, saturating
- hit  out  1  one-cycle pulse on collision
- game_over  out  1  high in OVER state

Behaviour:
- Reset (clear=1 at CLK edge):
  - state=PLAY, player_col=COLS/2, lives=LIVES, score=0, hit=0, game_over=0.
  - All objects inactive, spawn counter=0.
  - LFSR reloads LFSR_SEED.
  - clear overrides tick in the same cycle and is honoured in any state.
- LFSR: 16-bit Galois, taps 16'hB400, advances every CLK cycle (not only on tick).
  - New column = (lfsr[7:0]*COLS)>>8, always < COLS.
- States: PLAY, OVER.
  - PLAY -> OVER on the tick where lives go 1 -> 0.
  - OVER -> PLAY only via clear.
- Per tick in PLAY, all in one CLK cycle, results visible next cycle:
  1. Move.
     - Right alone and player_col<COLS-1: +1.
     - Left alone and player_col>0: -1.
     - Both or neither pressed: no move.
     - At an edge, a request toward the edge is ignored.
  2. Activation.
     - Object k activates (row=0, col from LFSR) on the tick where spawn counter == k*SPAWN_GAP.
     - Spawn counter increments per tick and saturates at (NUM_OBJ-1)*SPAWN_GAP.
  3. Advance.
     - Each active object that was already active at the start of the tick: row+1.
     - An object at row ROWS-1 instead respawns at row 0 with a fresh column and increments score (saturating at all-ones).
  4. Collision.
     - Checked on the updated positions, including the new player_col.
     - Any active object with col==player_col and row>=ROWS-PLAYER_H is a hit.
     - On a hit:
       - hit=1 for one cycle; lives-1 (once per tick, even if several objects hit).
       - All objects inactive, spawn counter=0.
       - No score for that tick, even if another object exited.
- Ticks in OVER: ignored, no state change, hit stays 0.
- Read port:
  - obj_row_n bit r=0 iff an active object sits at (rd_col, r).
  - player_row_n bit r=0 iff rd_col==player_col and r>=ROWS-PLAYER_H.
  - In OVER: obj_row_n shows an X (bit r low iff r==rd_col or r==ROWS-1-rd_col), and player_row_n = all 1s.
  - rd_col>=COLS: both outputs all 1s.
- Overlap: objects may share a cell; the display shows the OR.
- life_bar = (1<<lives)-1.

Optional Feature:
- Macro: DODGE_SPEEDUP_EN.
- Defined:
  - Objects advance only every fall_div ticks.
  - fall_div = 4 at reset and after each hit.
  - fall_div decrements by 1 (min 1) every 8 points of score.
  - Player moves on every tick regardless.
  - Collision is evaluated only on advancing ticks and on ticks where the player moves.
- Undefined: objects advance on every tick (fall_div fixed at 1), no divider logic present.

Test Plan:
- Reset then 8 ticks with Right=1 -> player_col goes 4,5,6,7 then stays 7; player_row_n at rd_col=7 = 8'b00111111.
- Left=Right=1 on a tick at player_col=4 -> stays 4; Left/Right toggled with no tick -> no change.
- NUM_OBJ=1, force the LFSR column away from the player, run ROWS+1 ticks -> object reaches row 7, respawns row 0, score=1.
- Object falls into player column -> hit pulses once, lives 3->2, life_bar 3'b011, all objects inactive, score unchanged; an exit in the same tick is not scored.
- Three hits -> lives=0, game_over=1, obj_row_n at rd_col=0 = 8'b01111110, further ticks ignored; clear -> lives=3, PLAY.
- clear asserted in the same cycle as tick mid-game -> reset values next cycle, no move, no hit.

Source files
------------

// File: rtl/dodge_engine_if.sv
// Bus between the dodge game core and the display/input logic around it.
// tick is a one-cycle strobe with no backpressure: every cycle it is high is one game step.
interface dodge_engine_if #(
  parameter int COLS    = 8,
  parameter int ROWS    = 8,
  parameter int LIVES   = 3,
  parameter int SCORE_W = 8
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic               tick;
  logic               Left;
  logic               Right;
  logic [CW-1:0]      rd_col;
  logic [ROWS-1:0]    obj_row_n;
  logic [ROWS-1:0]    player_row_n;
  logic [CW-1:0]      player_col;
  logic [2:0]         lives;
  logic [LIVES-1:0]   life_bar;
  logic [SCORE_W-1:0] score;
  logic               hit;
  logic               game_over;
  logic [0:0]         state_dbg;

  modport master (
    output tick, Left, Right, rd_col,
    input  obj_row_n, player_row_n, player_col, lives, life_bar, score, hit, game_over,
           state_dbg
  );

  modport slave (
    input  tick, Left, Right, rd_col,
    output obj_row_n, player_row_n, player_col, lives, life_bar, score, hit, game_over,
           state_dbg
  );
endinterface

// File: rtl/dodge_engine.sv
// Falling-object dodge game core: objects, LFSR spawning, player, collision, lives, score.
// Optional macro DODGE_SPEEDUP_EN: objects fall every fall_div ticks, speeding up with score.
module dodge_engine #(
  parameter int          COLS      = 8,
  parameter int          ROWS      = 8,
  parameter int          NUM_OBJ   = 3,
  parameter int          PLAYER_H  = 2,
  parameter int          LIVES     = 3,
  parameter int          SPAWN_GAP = 3,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic           CLK,
  input logic           clear,
  dodge_engine_if.slave bus
);
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW        = $clog2(ROWS);
  localparam int SPAWN_MAX = (NUM_OBJ - 1) * SPAWN_GAP;
  localparam int SW        = $clog2(SPAWN_MAX + 1) + 1;

  localparam logic [0:0] ST_PLAY = 1'b0;
  localparam logic [0:0] ST_OVER = 1'b1;

  logic [0:0]         state_q, state_n;
  logic [CW-1:0]      col_q, col_n;
  logic [2:0]         lives_q, lives_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic               hit_q, hit_n;
  logic [SW-1:0]      spawn_q, spawn_n;
  logic [15:0]        lfsr_q;
  logic [NUM_OBJ-1:0] act_q, act_n;
  logic [RW-1:0]      row_q  [NUM_OBJ];
  logic [RW-1:0]      row_n  [NUM_OBJ];
  logic [CW-1:0]      ocol_q [NUM_OBJ];
  logic [CW-1:0]      ocol_n [NUM_OBJ];

  logic [15:0]          prod;
  logic [CW-1:0]        new_col;
  logic                 advance;
  logic                 collide;
  logic [3:0]           exits;
  logic [SCORE_W+3:0]   score_sum;

  // Scaling the low LFSR byte by COLS keeps the column in range without a modulo.
  assign prod    = {8'd0, lfsr_q[7:0]} * 16'(COLS);
  assign new_col = CW'(prod >> 8);

`ifdef DODGE_SPEEDUP_EN
  logic [2:0] div_q, div_n, fcnt_q, fcnt_n;
  assign advance = ((fcnt_q + 3'd1) >= div_q);
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_n   = state_q;
    col_n     = col_q;
    lives_n   = lives_q;
    score_n   = score_q;
    hit_n     = 1'b0;
    spawn_n   = spawn_q;
    act_n     = act_q;
    row_n     = row_q;
    ocol_n    = ocol_q;
    collide   = 1'b0;
    exits     = '0;
    score_sum = '0;
`ifdef DODGE_SPEEDUP_EN
    div_n     = div_q;
    fcnt_n    = fcnt_q;
`endif
    if (bus.tick && state_q == ST_PLAY) begin
      if (bus.Right && !bus.Left && col_q != CW'(COLS - 1)) col_n = col_q + 1'b1;
      else if (bus.Left && !bus.Right && col_q != '0)      col_n = col_q - 1'b1;

      // Objects active at tick start fall; inactive ones wait for their spawn slot.
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (act_q[k]) begin
          if (advance) begin
            if (row_q[k] == RW'(ROWS - 1)) begin
              row_n[k]  = '0;
              ocol_n[k] = new_col;
              exits     = exits + 4'd1;
            end else begin
              row_n[k] = row_q[k] + 1'b1;
            end
          end
        end else if (spawn_q == SW'(k * SPAWN_GAP)) begin
          act_n[k]  = 1'b1;
          row_n[k]  = '0;
          ocol_n[k] = new_col;
        end
      end
      if (spawn_q != SW'(SPAWN_MAX)) spawn_n = spawn_q + 1'b1;

      for (int k = 0; k < NUM_OBJ; k++) begin
        if (act_n[k] && ocol_n[k] == col_n && row_n[k] >= RW'(ROWS - PLAYER_H)) collide = 1'b1;
      end
`ifdef DODGE_SPEEDUP_EN
      if (!advance && col_n == col_q) collide = 1'b0;
      fcnt_n = advance ? 3'd0 : fcnt_q + 3'd1;
`endif

      if (collide) begin
        hit_n   = 1'b1;
        lives_n = lives_q - 3'd1;
        act_n   = '0;
        spawn_n = '0;
        if (lives_q == 3'd1) state_n = ST_OVER;
`ifdef DODGE_SPEEDUP_EN
        div_n  = 3'd4;
        fcnt_n = 3'd0;
`endif
      end else begin
        score_sum = {4'd0, score_q} + {{SCORE_W{1'b0}}, exits};
        if (score_sum[SCORE_W+3:SCORE_W] != 4'd0) score_n = '1;
        else                                      score_n = score_sum[SCORE_W-1:0];
`ifdef DODGE_SPEEDUP_EN
        if (score_n[SCORE_W-1:3] != score_q[SCORE_W-1:3] && div_q > 3'd1) div_n = div_q - 3'd1;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q <= ST_PLAY;
      col_q   <= CW'(COLS / 2);
      lives_q <= 3'(LIVES);
      score_q <= '0;
      hit_q   <= 1'b0;
      spawn_q <= '0;
      lfsr_q  <= LFSR_SEED;
      act_q   <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        row_q[k]  <= '0;
        ocol_q[k] <= '0;
      end
    end else begin
      state_q <= state_n;
      col_q   <= col_n;
      lives_q <= lives_n;
      score_q <= score_n;
      hit_q   <= hit_n;
      spawn_q <= spawn_n;
      lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      act_q   <= act_n;
      row_q   <= row_n;
      ocol_q  <= ocol_n;
    end
  end

`ifdef DODGE_SPEEDUP_EN
  always_ff @(posedge CLK) begin
    if (clear) begin
      div_q  <= 3'd4;
      fcnt_q <= 3'd0;
    end else begin
      div_q  <= div_n;
      fcnt_q <= fcnt_n;
    end
  end
`endif

  // Column read port; the game-over screen replaces the field with an X.
  always_comb begin
    int rc;
    rc               = int'(bus.rd_col);
    bus.obj_row_n    = '1;
    bus.player_row_n = '1;
    if (rc < COLS) begin
      if (state_q == ST_OVER) begin
        for (int r = 0; r < ROWS; r++) begin
          if (r == rc || r == ROWS - 1 - rc) bus.obj_row_n[r] = 1'b0;
        end
      end else begin
        for (int r = 0; r < ROWS; r++) begin
          for (int k = 0; k < NUM_OBJ; k++) begin
            if (act_q[k] && ocol_q[k] == bus.rd_col && row_q[k] == RW'(r)) bus.obj_row_n[r] = 1'b0;
          end
          if (bus.rd_col == col_q && r >= ROWS - PLAYER_H) bus.player_row_n[r] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.life_bar = '0;
    for (int i = 0; i < LIVES; i++) bus.life_bar[i] = (lives_q > 3'(i));
  end

  assign bus.player_col = col_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.hit        = hit_q;
  assign bus.game_over  = (state_q == ST_OVER);
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_dodge_engine.sv
// Bench for dodge_engine: directed moves/game-over plus random play against a game-rule model.
module tb_dodge_engine;
  localparam int          COLS      = 8;
  localparam int          ROWS      = 8;
  localparam int          NUM_OBJ   = 3;
  localparam int          PLAYER_H  = 2;
  localparam int          LIVES     = 3;
  localparam int          SPAWN_GAP = 3;
  localparam int          SCORE_W   = 8;
  localparam logic [15:0] SEED      = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic clear;
  always #10 CLK = ~CLK;

  dodge_engine_if #(.COLS(COLS), .ROWS(ROWS), .LIVES(LIVES), .SCORE_W(SCORE_W)) bus ();

  dodge_engine #(
    .COLS(COLS), .ROWS(ROWS), .NUM_OBJ(NUM_OBJ), .PLAYER_H(PLAYER_H), .LIVES(LIVES),
    .SPAWN_GAP(SPAWN_GAP), .SCORE_W(SCORE_W), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK),
    .clear(clear),
    .bus(bus)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [SCORE_W-1:0] exp_q[$];

  int          m_col, m_lives, m_score, m_spawn;
  bit          m_over, m_hit;
  logic [15:0] m_lfsr;
  bit          o_act [NUM_OBJ];
  int          o_row [NUM_OBJ];
  int          o_col [NUM_OBJ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One CLK edge of the game rules; tick work uses the LFSR value held before the edge.
  task automatic model_edge(input bit t, input bit l, input bit r, input bit c);
    bit was [NUM_OBJ];
    int nc;
    int ex;
    bit any;
    ex  = 0;
    any = 0;
    if (c) begin
      m_col = COLS / 2; m_lives = LIVES; m_score = 0; m_spawn = 0;
      m_over = 0; m_hit = 0; m_lfsr = SEED;
      for (int k = 0; k < NUM_OBJ; k++) begin o_act[k] = 0; o_row[k] = 0; o_col[k] = 0; end
    end else begin
      m_hit = 0;
      if (t && !m_over) begin
        nc = (int'(m_lfsr[7:0]) * COLS) / 256;
        if (r && !l && m_col < COLS - 1) m_col++;
        else if (l && !r && m_col > 0)   m_col--;
        for (int k = 0; k < NUM_OBJ; k++) was[k] = o_act[k];
        for (int k = 0; k < NUM_OBJ; k++) begin
          if (was[k]) begin
            if (o_row[k] == ROWS - 1) begin o_row[k] = 0; o_col[k] = nc; ex++; end
            else o_row[k]++;
          end else if (m_spawn == k * SPAWN_GAP) begin
            o_act[k] = 1; o_row[k] = 0; o_col[k] = nc;
          end
        end
        if (m_spawn < (NUM_OBJ - 1) * SPAWN_GAP) m_spawn++;
        for (int k = 0; k < NUM_OBJ; k++)
          if (o_act[k] && o_col[k] == m_col && o_row[k] >= ROWS - PLAYER_H) any = 1;
        if (any) begin
          m_hit = 1; m_lives--; m_spawn = 0;
          for (int k = 0; k < NUM_OBJ; k++) o_act[k] = 0;
          if (m_lives == 0) m_over = 1;
        end else begin
          m_score = m_score + ex;
          if (m_score > (1 << SCORE_W) - 1) m_score = (1 << SCORE_W) - 1;
        end
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    exp_q.push_back(SCORE_W'(m_score));
  endtask

  function automatic logic [ROWS-1:0] exp_obj(input int c);
    logic [ROWS-1:0] v;
    v = '1;
    if (m_over) begin
      v[c] = 1'b0;
      v[ROWS-1-c] = 1'b0;
    end else begin
      for (int k = 0; k < NUM_OBJ; k++)
        if (o_act[k] && o_col[k] == c) v[o_row[k]] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_player(input int c);
    logic [ROWS-1:0] v;
    v = '1;
    if (!m_over && c == m_col)
      for (int r = ROWS - PLAYER_H; r < ROWS; r++) v[r] = 1'b0;
    return v;
  endfunction

  task automatic compare_all();
    logic [SCORE_W-1:0] es;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      es = exp_q.pop_front();
      check("score", 32'(bus.score), 32'(es));
    end
    check("player_col", 32'(bus.player_col), 32'(m_col));
    check("lives", 32'(bus.lives), 32'(m_lives));
    check("life_bar", 32'(bus.life_bar), 32'((1 << m_lives) - 1));
    check("hit", 32'(bus.hit), 32'(m_hit));
    check("game_over", 32'(bus.game_over), 32'(m_over));
    for (int c = 0; c < COLS; c++) begin
      bus.rd_col = 3'(c);
      #1;
      check("obj_row_n", 32'(bus.obj_row_n), 32'(exp_obj(c)));
      check("player_row_n", 32'(bus.player_row_n), 32'(exp_player(c)));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit t, input bit l, input bit r, input bit c);
    @(negedge CLK);
    bus.tick  = t;
    bus.Left  = l;
    bus.Right = r;
    clear     = c;
    @(posedge CLK);
    model_edge(t, l, r, c);
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    clear      = 1'b1;
    bus.tick   = 1'b0;
    bus.Left   = 1'b0;
    bus.Right  = 1'b0;
    bus.rd_col = '0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_col", 32'(bus.player_col), 32'd4);
    check("rst_lives", 32'(bus.lives), 32'd3);
    check("rst_score", 32'(bus.score), 32'd0);

    // Walk right into the edge.
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    check("edge_col", 32'(bus.player_col), 32'd7);
    bus.rd_col = 3'd7;
    #1;
    check("edge_prow", 32'(bus.player_row_n), 32'h3F);

    // Both pressed on a tick, then presses without a tick.
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    check("both_col", 32'(bus.player_col), 32'd4);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("notick_col", 32'(bus.player_col), 32'd4);

    // Random play with occasional clears.
    for (int i = 0; i < 2500; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 399) == 0));

    // Clear coinciding with a tick mid-game.
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    check("clr_tick_col", 32'(bus.player_col), 32'd4);
    check("clr_tick_hit", 32'(bus.hit), 32'd0);

    // Stand still until the game ends.
    n = 0;
    while (!bus.game_over && n < 4000) begin
      step(1, 0, 0, 0);
      n++;
    end
    check("reach_over", 32'(bus.game_over), 32'd1);
    bus.rd_col = 3'd0;
    #1;
    check("over_x_col0", 32'(bus.obj_row_n), 32'h7E);
    for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    check("over_lives", 32'(bus.lives), 32'd0);
    step(0, 0, 0, 1);
    check("restart_lives", 32'(bus.lives), 32'd3);
    check("restart_over", 32'(bus.game_over), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
